// File: rtl/alu_cmd_master.sv
// Host-side initiator for the UART-attached ALU: sends A, B, op as three bytes and returns the result byte.
// Optional feature macro ALU_CMD_TIMEOUT_EN: result wait bounded by TIMEOUT_CYCLES, reported via o_rsp_timeout.
module alu_cmd_master #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_TIMEOUT     = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_req_valid,
    input  logic [NB_DATA-1:0] i_req_a,
    input  logic [NB_DATA-1:0] i_req_b,
    input  logic [NB_OP-1:0]   i_req_op,
    output logic               o_req_ready,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done_tick,
    output logic               o_rsp_valid,
    output logic [NB_DATA-1:0] o_rsp_data,
    output logic               o_rsp_timeout,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] rsp_data_q;
    logic               rsp_valid_q;
    logic               accept;
    logic               rx_fire;
    logic               to_fire;

    // The strobe cycle is already IDLE; ready waits one more cycle so a held request starts after it.
    assign o_req_ready = (state_q == IDLE) && !rsp_valid_q;
    assign o_busy      = (state_q != IDLE);
    assign accept      = i_req_valid && o_req_ready;
    assign rx_fire     = (state_q == WAIT_RES) && i_rx_done_tick;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;

`ifdef ALU_CMD_TIMEOUT_EN
    logic [NB_TIMEOUT-1:0] cnt_q;
    logic                  rsp_timeout_q;

    // A result byte on the terminal cycle wins over the timeout.
    assign to_fire = (state_q == WAIT_RES) && !i_rx_done_tick &&
                     (cnt_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
    assign o_rsp_timeout = rsp_timeout_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == WAIT_RES) ? cnt_q + 1'b1 : '0;
            if (rx_fire || to_fire)
                rsp_timeout_q <= to_fire;
        end
    end
`else
    assign to_fire       = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rx_fire || to_fire;
            if (accept) begin
                a_q  <= i_req_a;
                b_q  <= i_req_b;
                op_q <= i_req_op;
            end
            if (rx_fire)
                rsp_data_q <= i_rx_data;
            else if (to_fire)
                rsp_data_q <= '0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        o_tx_start = 1'b0;
        o_tx_data  = '0;
        case (state_q)
            IDLE:     if (accept) state_d = SEND_A;
            SEND_A: begin
                o_tx_start = 1'b1;
                o_tx_data  = a_q;
                state_d    = WAIT_A;
            end
            WAIT_A: begin
                o_tx_data = a_q;
                if (i_tx_done_tick) state_d = SEND_B;
            end
            SEND_B: begin
                o_tx_start = 1'b1;
                o_tx_data  = b_q;
                state_d    = WAIT_B;
            end
            WAIT_B: begin
                o_tx_data = b_q;
                if (i_tx_done_tick) state_d = SEND_OP;
            end
            SEND_OP: begin
                o_tx_start = 1'b1;
                o_tx_data  = NB_DATA'(op_q);
                state_d    = WAIT_OP;
            end
            WAIT_OP: begin
                o_tx_data = NB_DATA'(op_q);
                if (i_tx_done_tick) state_d = WAIT_RES;
            end
            WAIT_RES: if (rx_fire || to_fire) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Scoreboard bench for alu_cmd_master: directed requests, UART TX model with a 10-cycle byte time,
// and a negedge monitor that checks every tx byte and response against queued expectations.
module tb_alu_cmd_master;

    localparam int NB_DATA   = 8;
    localparam int NB_OP     = 6;
    localparam int TO_CYCLES = 50;
    localparam int BYTE_TIME = 10;

    logic               i_clock        = 1'b0;
    logic               i_reset        = 1'b0;
    logic               i_req_valid    = 1'b0;
    logic [NB_DATA-1:0] i_req_a        = '0;
    logic [NB_DATA-1:0] i_req_b        = '0;
    logic [NB_OP-1:0]   i_req_op       = '0;
    logic               i_tx_done_tick = 1'b0;
    logic [NB_DATA-1:0] i_rx_data      = '0;
    logic               i_rx_done_tick = 1'b0;
    logic               o_req_ready;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_rsp_valid;
    logic [NB_DATA-1:0] o_rsp_data;
    logic               o_rsp_timeout;
    logic               o_busy;

    alu_cmd_master #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TIMEOUT(20), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
        .o_req_ready(o_req_ready),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done_tick(i_tx_done_tick),
        .i_rx_data(i_rx_data), .i_rx_done_tick(i_rx_done_tick),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_timeout(o_rsp_timeout),
        .o_busy(o_busy)
    );

    initial forever #5 i_clock = ~i_clock;

    typedef struct { logic [7:0] data; int gap; bit from_rsp; } tx_exp_t;
    typedef struct { logic [7:0] data; logic tmo; int lat; } rsp_exp_t;

    tx_exp_t  tx_q[$];
    rsp_exp_t rsp_q[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, last_start = 0, last_rsp = 0, n_rsp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    initial forever begin
        @(posedge i_clock);
        cyc++;
    end

    // UART transmitter model: done tick exactly BYTE_TIME cycles after each start.
    initial forever begin
        @(negedge i_clock);
        i_tx_done_tick = 1'b0;
        if (o_tx_start) begin
            repeat (BYTE_TIME) @(negedge i_clock);
            i_tx_done_tick = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a tx start or a response.
    initial begin : monitor
        tx_exp_t  te;
        rsp_exp_t re;
        forever begin
            @(negedge i_clock);
            if (i_reset) begin
                if (o_tx_start) begin
                    if (tx_q.size() == 0) fail_event("unexpected_tx_start");
                    else begin
                        te = tx_q.pop_front();
                        check("tx_byte", o_tx_data, te.data);
                        if (te.gap != 0)
                            check("tx_gap", cyc - (te.from_rsp ? last_rsp : last_start), te.gap);
                    end
                    last_start = cyc;
                end
                if (o_rsp_valid) begin
                    if (rsp_q.size() == 0) fail_event("unexpected_rsp_valid");
                    else begin
                        re = rsp_q.pop_front();
                        check("rsp_data", o_rsp_data, re.data);
                        check("rsp_timeout", o_rsp_timeout, re.tmo);
                        if (re.lat != 0) check("rsp_latency", cyc - last_start, re.lat);
                    end
                    last_rsp = cyc;
                    n_rsp++;
                end
            end
        end
    end

    task automatic expect_txn(input logic [7:0] a, b, input logic [5:0] op,
                              input logic [7:0] res, input logic tmo, input int lat, input int gap_a);
        tx_q.push_back('{a, gap_a, 1'b1});
        tx_q.push_back('{b, BYTE_TIME + 1, 1'b0});
        tx_q.push_back('{{2'b00, op}, BYTE_TIME + 1, 1'b0});
        rsp_q.push_back('{res, tmo, lat});
    endtask

    task automatic accept_req(input logic [7:0] a, b, input logic [5:0] op);
        int n = 0;
        @(negedge i_clock);
        i_req_a = a; i_req_b = b; i_req_op = op; i_req_valid = 1'b1;
        while (!o_req_ready) begin
            @(negedge i_clock);
            n++;
            if (n > 100) begin fail_event("accept_wait_expired"); return; end
        end
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        i_rx_data = d;
        i_rx_done_tick = 1'b1;
        @(negedge i_clock);
        i_rx_done_tick = 1'b0;
    endtask

    // Follows the three tx starts; optionally injects stray rx bytes and delivers the result
    // rx_delay cycles after the OP start.
    task automatic drive_txn_bytes(input logic [7:0] result, input int rx_delay, input bit give_rx,
                                   input bit inject, input bit keep_valid,
                                   input logic [7:0] na, nb, input logic [5:0] nop);
        int seen = 0, waited = 0, since3 = 0;
        while (seen < 3) begin
            int off;
            @(negedge i_clock);
            waited++;
            if (waited > 200) begin fail_event("tx_start_wait_expired"); return; end
            if (o_tx_start) begin
                seen++;
                if (seen == 1) begin
                    if (keep_valid) begin i_req_a = na; i_req_b = nb; i_req_op = nop; end
                    else i_req_valid = 1'b0;
                end
                if (inject) begin
                    off = (seen == 3) ? BYTE_TIME : 3;
                    repeat (off) @(negedge i_clock);
                    pulse_rx(8'hAA);
                    waited += off + 1;
                    if (seen == 3) since3 = off + 1;
                end
            end
        end
        if (give_rx) begin
            repeat (rx_delay - since3) @(negedge i_clock);
            pulse_rx(result);
        end
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (n_rsp < target) begin
            @(posedge i_clock);
            n++;
            if (n > 20000) begin fail_event("rsp_wait_expired"); return; end
        end
    endtask

    initial begin : stimulus
        int base, seen;
        // Reset values while held in reset.
        repeat (3) @(negedge i_clock);
        check("reset_ready", o_req_ready, 1);
        check("reset_busy", o_busy, 0);
        check("reset_tx_start", o_tx_start, 0);
        check("reset_rsp_valid", o_rsp_valid, 0);
        i_reset = 1'b1;

        // 1: reset during SEND_B, stale tx done tick afterwards.
        tx_q.push_back('{8'h12, 0, 1'b1});
        tx_q.push_back('{8'h34, BYTE_TIME + 1, 1'b0});
        accept_req(8'h12, 8'h34, 6'h01);
        seen = 0;
        while (seen < 2) begin
            @(negedge i_clock);
            if (o_tx_start) begin seen++; i_req_valid = 1'b0; end
        end
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        check("rst_mid_ready", o_req_ready, 1);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_tx_start", o_tx_start, 0);
        check("rst_mid_tx_data", o_tx_data, 0);
        check("rst_mid_rsp_valid", o_rsp_valid, 0);
        check("rst_mid_rsp_data", o_rsp_data, 0);
        check("rst_mid_rsp_timeout", o_rsp_timeout, 0);
        repeat (15) @(negedge i_clock);
        check("stale_tick_busy", o_busy, 0);
        check("stale_tick_ready", o_req_ready, 1);

        // 2: basic request 5 + 3 -> 0x08, result 15 cycles after OP start.
        base = n_rsp;
        expect_txn(8'h05, 8'h03, 6'h20, 8'h08, 1'b0, 16, 0);
        accept_req(8'h05, 8'h03, 6'h20);
        drive_txn_bytes(8'h08, 15, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        wait_rsp(base + 1);
        repeat (5) @(negedge i_clock);
        check("rsp_data_held", o_rsp_data, 8'h08);

        // 3: op 0x3F, request held valid across two back-to-back transactions.
        base = n_rsp;
        expect_txn(8'h10, 8'h22, 6'h3F, 8'h55, 1'b0, 16, 0);
        expect_txn(8'h01, 8'h02, 6'h3F, 8'h66, 1'b0, 16, 2);
        accept_req(8'h10, 8'h22, 6'h3F);
        drive_txn_bytes(8'h55, 15, 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 6'h3F);
        drive_txn_bytes(8'h66, 15, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        wait_rsp(base + 2);
        repeat (30) @(negedge i_clock);
        check("b2b_rsp_count", n_rsp - base, 2);

        // 4: stray rx bytes in WAIT_A, WAIT_B and coincident with the WAIT_OP done tick.
        base = n_rsp;
        expect_txn(8'h40, 8'h41, 6'h02, 8'h11, 1'b0, 16, 0);
        accept_req(8'h40, 8'h41, 6'h02);
        drive_txn_bytes(8'h11, 15, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
        wait_rsp(base + 1);

`ifdef ALU_CMD_TIMEOUT_EN
        // 5a: no result byte: timeout strobe 50 cycles after entering WAIT_RES.
        base = n_rsp;
        expect_txn(8'h07, 8'h09, 6'h05, 8'h00, 1'b1, BYTE_TIME + 1 + TO_CYCLES, 0);
        accept_req(8'h07, 8'h09, 6'h05);
        drive_txn_bytes(8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        wait_rsp(base + 1);
        @(negedge i_clock);
        check("timeout_then_ready", o_req_ready, 1);

        // 5b: result byte on the terminal cycle wins.
        base = n_rsp;
        expect_txn(8'h0A, 8'h0B, 6'h06, 8'h5A, 1'b0, BYTE_TIME + 1 + TO_CYCLES, 0);
        accept_req(8'h0A, 8'h0B, 6'h06);
        drive_txn_bytes(8'h5A, BYTE_TIME + TO_CYCLES, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        wait_rsp(base + 1);
`else
        // 6: no timeout: a long silence keeps the master busy, a late byte completes it.
        base = n_rsp;
        expect_txn(8'h21, 8'h22, 6'h03, 8'h7E, 1'b0, 0, 0);
        accept_req(8'h21, 8'h22, 6'h03);
        drive_txn_bytes(8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        for (int i = 0; i < 5; i++) begin
            repeat (1000) @(negedge i_clock);
            check("long_wait_busy", o_busy, 1);
        end
        check("long_wait_no_rsp", n_rsp - base, 0);
        pulse_rx(8'h7E);
        wait_rsp(base + 1);
        @(negedge i_clock);
        check("late_rsp_then_ready", o_req_ready, 1);
`endif

        repeat (20) @(negedge i_clock);
        check("tx_queue_left", tx_q.size(), 0);
        check("rsp_queue_left", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
